// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU beside the EXE stage.
// Returns {remainder, quotient}. Optional feature macro: DIV_EARLY_OUT_EN
// (skip the iteration loop when |dividend| < |divisor|).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StZero = 2'd1;
  localparam logic [1:0] StBusy = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH:0]     rem_q, rem_d;     // one extra bit for the trial subtract
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes, trial subtraction and final sign correction.
  always_comb begin
    abs_a   = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    abs_b   = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (annul) begin
      // Kill wins over everything; result keeps its last value.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            dvs_d     = abs_b;
            quo_d     = abs_a;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem_d = signed_div & opdata1[WIDTH-1];
            if (opdata2 == '0) begin
              state_d = StZero;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs_a < abs_b) begin
              // Answer is known: park in BUSY at the final count so the
              // sign-correction step produces q=0, r=dividend next edge.
              quo_d   = '0;
              rem_d   = {1'b0, abs_a};
              cnt_d   = CntLast;
              state_d = StBusy;
`endif
            end else begin
              state_d = StBusy;
            end
          end
        end
        StZero: begin
          // Two-edge dwell so a zero-divisor op reports ready at edge 2.
          if (cnt_q == '0) begin
            cnt_d = CntW'(1);
          end else begin
            result_d = '0;
            state_d  = StDone;
          end
        end
        StBusy: begin
          if (cnt_q == CntLast) begin
            result_d = {rem_fix, quo_fix};
            state_d  = StDone;
          end else begin
            rem_d = diff[WIDTH] ? shifted : diff;
            quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (!start) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // Outputs; stall drops in DONE so the pipeline advances as it consumes result.
  always_comb begin
    result    = result_q;
    ready     = (state_q == StDone);
    stall_req = start & ~ready & ~annul;
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: behavioural latency/result model,
// per-cycle compare, directed literal cases and randomized operations.
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif
  localparam int FullLat = 33;
  localparam int EoLat   = EarlyOut ? 1 : FullLat;

  logic        clk = 1'b0;
  logic        reset, start, signed_div, annul;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic        ready, stall_req;

  int vectors = 0;
  int miscompares = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .result(result), .ready(ready), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: 64-bit integer division truncates toward zero and
  // the remainder follows the dividend, exactly the DIV/DIVU semantics.
  function automatic logic [63:0] model_div(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(logic [31:0] a, logic [31:0] b, logic s);
    longint ma, mb;
    if (b == 32'd0) return 2;
    ma = (s && a[31]) ? -longint'($signed(a)) : longint'({32'd0, a});
    mb = (s && b[31]) ? -longint'($signed(b)) : longint'({32'd0, b});
    if (EarlyOut && ma < mb) return 1;
    return FullLat;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op sampled at edge 0 shows ready from edge 'lat' until start drops.
  int          m_phase, m_cnt, m_lat;
  logic        m_ready;
  logic [63:0] m_result, m_exp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  <= 0;
      m_cnt    <= 0;
      m_ready  <= 1'b0;
      m_result <= '0;
    end else if (annul) begin
      m_phase <= 0;
      m_ready <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_exp   <= model_div(opdata1, opdata2, signed_div);
          m_lat   <= model_lat(opdata1, opdata2, signed_div);
          m_cnt   <= 0;
          m_phase <= 1;
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_lat) begin
            m_ready  <= 1'b1;
            m_result <= m_exp;
            m_phase  <= 2;
          end
        end
        default: if (!start) begin
          m_phase <= 0;
          m_ready <= 1'b0;
        end
      endcase
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    check("ready", {63'd0, ready}, {63'd0, m_ready});
    check("stall_req", {63'd0, stall_req}, {63'd0, start & ~m_ready & ~annul});
    check("result", result, m_result);
  end

  // Directed op with literal expectations; called #1 after a posedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] lit, input int lit_lat);
    int n;
    n = 0;
    opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        n = i;
        break;
      end
    end
    check("latency", 64'(n), 64'(lit_lat));
    check("lit_result", result, lit);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Random op with operand scrambling during BUSY and occasional kill.
  task automatic rand_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int  kill;
    bit  done;
    done = 1'b0;
    kill = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : 0;
    opdata1 = a; opdata2 = b; signed_div = s; start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
      if (kill == i) begin
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        done = 1'b1;
        break;
      end
      if (ready) begin
        done = 1'b1;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        break;
      end
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;
    #1;
    check("reset_result", result, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, FullLat);
    run_op(-32'sd7, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, FullLat);
    run_op(32'd7, -32'sd2, 1'b1, {32'd1, 32'hFFFFFFFD}, FullLat);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000}, FullLat);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'd0}, EoLat);
    run_op(32'd12345, 32'd0, 1'b1, 64'd0, 2);
    run_op(32'd3, 32'd10, 1'b0, {32'd3, 32'd0}, EoLat);

    // Kill at edge 10 of BUSY, then a fresh full op.
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1;
    check("annul_ready", {63'd0, ready}, 64'd0);
    annul = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_op(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, FullLat);

    // Asynchronous reset mid-operation, with a non-zero result held.
    opdata1 = 32'd50; opdata2 = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    #1;
    check("midreset_result", result, 64'd0);
    check("midreset_ready", {63'd0, ready}, 64'd0);
    check("midreset_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = $urandom_range(0, 20);
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      rand_op(a, b, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
